// File: rtl/stream_width_gearbox_pkg.sv
// Shared helpers for the stream converters: width math and common word sizes.
package stream_width_gearbox_pkg;

  localparam int BYTE_LEN  = 8;
  localparam int DIBIT_LEN = 2;
  localparam int COLOR_LEN = 12;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_width_gearbox_bit_reverse.sv
// Pure combinational bit-order mirror; lets the gearbox core stay LSB-first.
module stream_width_gearbox_bit_reverse
  import stream_width_gearbox_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] word,
  output logic [W-1:0] mirrored
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign mirrored[i] = word[W-1-i];
  end

endmodule

// File: rtl/stream_width_gearbox.sv
// Repacks a strobed stream of IN_LEN-bit words into OUT_LEN-bit words, with
// stall, end-of-stream flush (optional zero padding) and sticky overflow.
module stream_width_gearbox
  import stream_width_gearbox_pkg::*;
#(
  parameter int IN_LEN      = 8,
  parameter int OUT_LEN     = 2,
  parameter int MSB_FIRST   = 0,
  parameter int PAD_PARTIAL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inclk,
  input  logic [IN_LEN-1:0]  in,
  input  logic               in_done,
  input  logic               downstream_rdy,
  output logic               rdy,
  output logic               outclk,
  output logic [OUT_LEN-1:0] out,
  output logic               done,
  output logic               overflow
);

  localparam int BUF_LEN = IN_LEN + OUT_LEN;
  localparam int CW      = clog2(BUF_LEN + 1);

  localparam logic [CW-1:0] IN_CNT  = CW'(IN_LEN);
  localparam logic [CW-1:0] OUT_CNT = CW'(OUT_LEN);
  localparam logic [CW-1:0] ACC_MAX = CW'(BUF_LEN - IN_LEN);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt, cnt_mid, cnt_nxt;
  logic [BUF_LEN-1:0] sbuf, sbuf_mid, sbuf_nxt;
  logic [IN_LEN-1:0]  in_lsb;
  logic [OUT_LEN-1:0] word_lsb, word_out;
  logic               accept, full_emit, partial, pad_emit, discard, emit;

  // The core only ever sees LSB-first data; MSB-first mirrors both ends.
  if (MSB_FIRST != 0) begin : g_msb
    stream_width_gearbox_bit_reverse #(.W(IN_LEN)) u_rev_in (
      .word     (in),
      .mirrored (in_lsb)
    );
    stream_width_gearbox_bit_reverse #(.W(OUT_LEN)) u_rev_out (
      .word     (word_lsb),
      .mirrored (word_out)
    );
  end else begin : g_lsb
    assign in_lsb   = in;
    assign word_out = word_lsb;
  end

  assign rdy       = (state == ST_RUN) && (cnt <= ACC_MAX);
  assign accept    = inclk && rdy;
  assign full_emit = (cnt >= OUT_CNT) && downstream_rdy;
  assign partial   = (state == ST_FLUSH) && (cnt != '0) && (cnt < OUT_CNT);
  assign pad_emit  = partial && downstream_rdy && (PAD_PARTIAL != 0);
  assign discard   = partial && (PAD_PARTIAL == 0);
  assign emit      = full_emit || pad_emit;
  assign done      = (state == ST_DONE);

  // Bits at or above cnt are kept zero, so a partial word is already padded.
  assign word_lsb = sbuf[OUT_LEN-1:0];

  always_comb begin
    sbuf_mid = sbuf;
    cnt_mid  = cnt;
    if (full_emit) begin
      sbuf_mid = sbuf >> OUT_LEN;
      cnt_mid  = cnt - OUT_CNT;
    end
    if (pad_emit || discard) begin
      sbuf_mid = '0;
      cnt_mid  = '0;
    end
    sbuf_nxt = sbuf_mid;
    cnt_nxt  = cnt_mid;
    if (accept) begin
      sbuf_nxt = sbuf_mid | (BUF_LEN'(in_lsb) << cnt_mid);
      cnt_nxt  = cnt_mid + IN_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= '0;
      sbuf     <= '0;
      outclk   <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sbuf   <= sbuf_nxt;
      outclk <= emit;
      if (emit) out <= word_out;
      // Words arriving during flush belong to no stream and are not overflow.
      if (inclk && !rdy && (state != ST_FLUSH)) overflow <= 1'b1;
      case (state)
        ST_RUN:   if (in_done) state <= ST_FLUSH;
        ST_FLUSH: if (cnt == '0) state <= ST_DONE;
        ST_DONE:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_width_gearbox.sv
// Directed bench for stream_width_gearbox across several width/order configurations.
module tb_stream_width_gearbox;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] inclk, in_done, dsr, rdy, outclk, done, ovf;
  logic [7:0] din;
  logic [1:0] din2;
  logic [1:0] o0;
  logic [7:0] o1;
  logic [11:0] o2, o3, o4;

  typedef struct { int id; logic [11:0] v; } cap_t;
  cap_t cap[$];
  int done_cnt [5] = '{default: 0};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: 8->2 LSB, u1: 2->8 LSB, u2: 8->12 LSB pad, u3: 8->12 MSB pad, u4: 8->12 LSB no pad
  stream_width_gearbox #(.IN_LEN(8), .OUT_LEN(2), .MSB_FIRST(0), .PAD_PARTIAL(1)) u0 (
    .clk(clk), .rst(rst), .inclk(inclk[0]), .in(din), .in_done(in_done[0]),
    .downstream_rdy(dsr[0]), .rdy(rdy[0]), .outclk(outclk[0]), .out(o0),
    .done(done[0]), .overflow(ovf[0]));
  stream_width_gearbox #(.IN_LEN(2), .OUT_LEN(8), .MSB_FIRST(0), .PAD_PARTIAL(1)) u1 (
    .clk(clk), .rst(rst), .inclk(inclk[1]), .in(din2), .in_done(in_done[1]),
    .downstream_rdy(dsr[1]), .rdy(rdy[1]), .outclk(outclk[1]), .out(o1),
    .done(done[1]), .overflow(ovf[1]));
  stream_width_gearbox #(.IN_LEN(8), .OUT_LEN(12), .MSB_FIRST(0), .PAD_PARTIAL(1)) u2 (
    .clk(clk), .rst(rst), .inclk(inclk[2]), .in(din), .in_done(in_done[2]),
    .downstream_rdy(dsr[2]), .rdy(rdy[2]), .outclk(outclk[2]), .out(o2),
    .done(done[2]), .overflow(ovf[2]));
  stream_width_gearbox #(.IN_LEN(8), .OUT_LEN(12), .MSB_FIRST(1), .PAD_PARTIAL(1)) u3 (
    .clk(clk), .rst(rst), .inclk(inclk[3]), .in(din), .in_done(in_done[3]),
    .downstream_rdy(dsr[3]), .rdy(rdy[3]), .outclk(outclk[3]), .out(o3),
    .done(done[3]), .overflow(ovf[3]));
  stream_width_gearbox #(.IN_LEN(8), .OUT_LEN(12), .MSB_FIRST(0), .PAD_PARTIAL(0)) u4 (
    .clk(clk), .rst(rst), .inclk(inclk[4]), .in(din), .in_done(in_done[4]),
    .downstream_rdy(dsr[4]), .rdy(rdy[4]), .outclk(outclk[4]), .out(o4),
    .done(done[4]), .overflow(ovf[4]));

  // Scoreboard capture of every output word and done pulse.
  always @(negedge clk) begin
    if (outclk[0]) cap.push_back('{0, {10'd0, o0}});
    if (outclk[1]) cap.push_back('{1, {4'd0, o1}});
    if (outclk[2]) cap.push_back('{2, o2});
    if (outclk[3]) cap.push_back('{3, o3});
    if (outclk[4]) cap.push_back('{4, o4});
    for (int i = 0; i < 5; i++) if (done[i]) done_cnt[i]++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inclk = '0; in_done = '0; dsr = '1; din = '0; din2 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (rdy !== 5'h1f) begin errors++; $display("FAIL reset_rdy got %b want %b", rdy, 5'h1f); end
    checks++; if (outclk !== 5'h00) begin errors++; $display("FAIL reset_outclk got %b want 00000", outclk); end
    checks++; if (done !== 5'h00) begin errors++; $display("FAIL reset_done got %b want 00000", done); end
    checks++; if (ovf !== 5'h00) begin errors++; $display("FAIL reset_overflow got %b want 00000", ovf); end
    checks++; if (o0 !== 2'b00 || o2 !== 12'h000 || o3 !== 12'h000) begin
      errors++; $display("FAIL reset_out got %h %h %h want 0 0 0", o0, o2, o3); end
  endtask

  task automatic test_8to2();
    int b;
    logic [11:0] e [4];
    e = '{12'h1, 12'h1, 12'h1, 12'h3};
    b = cap.size();
    inclk[0] = 1'b1; din = 8'hD5;
    step();
    inclk[0] = 1'b0;
    checks++; if (outclk[0] !== 1'b0) begin errors++; $display("FAIL d2_latency1 got %b want 0", outclk[0]); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL d2_rdy_full got %b want 0", rdy[0]); end
    step();
    checks++; if (outclk[0] !== 1'b1 || o0 !== 2'b01) begin
      errors++; $display("FAIL d2_latency2 got outclk=%b out=%b want 1 01", outclk[0], o0); end
    repeat (5) step();
    checks++; if (cap.size() - b != 4) begin errors++; $display("FAIL d2_count got %0d want 4", cap.size() - b); end
    if (cap.size() >= b + 4)
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap[b+k].id != 0 || cap[b+k].v !== e[k]) begin
          errors++; $display("FAIL d2_word%0d got id%0d %h want id0 %h", k, cap[b+k].id, cap[b+k].v, e[k]); end
      end
    in_done[0] = 1'b1;
    step();
    in_done[0] = 1'b0;
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL d2_done_early got %b want 0", done[0]); end
    step();
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL d2_done_pulse got %b want 1", done[0]); end
    step();
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL d2_done_width got %b want 0", done[0]); end
    checks++; if (cap.size() != b + 4) begin errors++; $display("FAIL d2_no_pad got %0d want %0d", cap.size(), b + 4); end
  endtask

  task automatic test_2to8();
    int b;
    logic [1:0] seq [8];
    seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3};
    b = cap.size();
    for (int k = 0; k < 8; k++) begin
      inclk[1] = 1'b1; din2 = seq[k];
      step();
    end
    inclk[1] = 1'b0;
    repeat (3) step();
    checks++; if (cap.size() - b != 2) begin errors++; $display("FAIL u2_count got %0d want 2", cap.size() - b); end
    if (cap.size() >= b + 2) begin
      checks++; if (cap[b].id != 1 || cap[b].v !== 12'h0AA) begin
        errors++; $display("FAIL u2_word0 got id%0d %h want id1 0aa", cap[b].id, cap[b].v); end
      checks++; if (cap[b+1].id != 1 || cap[b+1].v !== 12'h0D5) begin
        errors++; $display("FAIL u2_word1 got id%0d %h want id1 0d5", cap[b+1].id, cap[b+1].v); end
    end
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL u2_overflow got %b want 0", ovf[1]); end
  endtask

  task automatic test_8to12();
    int b;
    int ids [4];
    logic [11:0] e [4];
    ids = '{2, 3, 2, 3};
    e = '{12'hDDE, 12'hDEA, 12'hBEA, 12'hDBE};
    b = cap.size();
    inclk[2] = 1'b1; inclk[3] = 1'b1; din = 8'hDE;
    step();
    din = 8'hAD;
    step();
    inclk[2] = 1'b0; inclk[3] = 1'b0;
    checks++; if (rdy[3:2] !== 2'b00) begin errors++; $display("FAIL w12_rdy_full got %b want 00", rdy[3:2]); end
    step();
    checks++; if (rdy[3:2] !== 2'b11) begin errors++; $display("FAIL w12_rdy_free got %b want 11", rdy[3:2]); end
    inclk[2] = 1'b1; inclk[3] = 1'b1; din = 8'hBE;
    step();
    inclk[2] = 1'b0; inclk[3] = 1'b0;
    repeat (3) step();
    checks++; if (cap.size() - b != 4) begin errors++; $display("FAIL w12_count got %0d want 4", cap.size() - b); end
    if (cap.size() >= b + 4)
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap[b+k].id != ids[k] || cap[b+k].v !== e[k]) begin
          errors++; $display("FAIL w12_word%0d got id%0d %h want id%0d %h", k, cap[b+k].id, cap[b+k].v, ids[k], e[k]); end
      end
  endtask

  task automatic test_flush_pad();
    int b, d2, d4;
    int ids [3];
    logic [11:0] e [3];
    ids = '{2, 4, 2};
    e = '{12'hDDE, 12'hDDE, 12'h00A};
    b = cap.size(); d2 = done_cnt[2]; d4 = done_cnt[4];
    inclk[2] = 1'b1; inclk[4] = 1'b1; din = 8'hDE;
    step();
    din = 8'hAD; in_done[2] = 1'b1; in_done[4] = 1'b1;
    step();
    inclk[2] = 1'b0; inclk[4] = 1'b0; in_done[2] = 1'b0; in_done[4] = 1'b0;
    repeat (6) step();
    checks++; if (cap.size() - b != 3) begin errors++; $display("FAIL pad_count got %0d want 3", cap.size() - b); end
    if (cap.size() >= b + 3)
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap[b+k].id != ids[k] || cap[b+k].v !== e[k]) begin
          errors++; $display("FAIL pad_word%0d got id%0d %h want id%0d %h", k, cap[b+k].id, cap[b+k].v, ids[k], e[k]); end
      end
    checks++; if (done_cnt[2] - d2 != 1) begin errors++; $display("FAIL pad_done got %0d want 1", done_cnt[2] - d2); end
    checks++; if (done_cnt[4] - d4 != 1) begin errors++; $display("FAIL nopad_done got %0d want 1", done_cnt[4] - d4); end
    checks++; if (rdy[2] !== 1'b1 || rdy[4] !== 1'b1) begin
      errors++; $display("FAIL pad_rdy_after got %b%b want 11", rdy[2], rdy[4]); end
  endtask

  task automatic test_overflow_stall();
    int b;
    logic [11:0] e [4];
    e = '{12'h1, 12'h0, 12'h0, 12'h0};
    b = cap.size();
    inclk[0] = 1'b1; din = 8'h01;
    step();
    din = 8'h02;
    step();
    inclk[0] = 1'b0; dsr[0] = 1'b0;
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf[0]); end
    checks++; if (outclk[0] !== 1'b1 || o0 !== 2'b01) begin
      errors++; $display("FAIL ovf_first got outclk=%b out=%b want 1 01", outclk[0], o0); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (outclk[0] !== 1'b0 || o0 !== 2'b01 || rdy[0] !== 1'b0) begin
        errors++; $display("FAIL stall%0d got outclk=%b out=%b rdy=%b want 0 01 0", k, outclk[0], o0, rdy[0]); end
    end
    dsr[0] = 1'b1;
    repeat (4) step();
    checks++; if (cap.size() - b != 4) begin errors++; $display("FAIL ovf_count got %0d want 4", cap.size() - b); end
    if (cap.size() >= b + 4)
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap[b+k].id != 0 || cap[b+k].v !== e[k]) begin
          errors++; $display("FAIL ovf_word%0d got id%0d %h want id0 %h", k, cap[b+k].id, cap[b+k].v, e[k]); end
      end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf[0]); end
  endtask

  task automatic test_reset_flush();
    int base, d2;
    d2 = done_cnt[2];
    inclk[2] = 1'b1; din = 8'hDE;
    step();
    din = 8'hAD;
    step();
    din = 8'hBE; in_done[2] = 1'b1;
    step();
    inclk[2] = 1'b0; in_done[2] = 1'b0; dsr[2] = 1'b0;
    checks++; if (ovf[2] !== 1'b1 || rdy[2] !== 1'b0 || outclk[2] !== 1'b1 || o2 !== 12'hDDE) begin
      errors++; $display("FAIL rf_pre got ovf=%b rdy=%b outclk=%b out=%h want 1 0 1 dde", ovf[2], rdy[2], outclk[2], o2); end
    step();
    checks++; if (outclk[2] !== 1'b0 || done[2] !== 1'b0) begin
      errors++; $display("FAIL rf_stall got outclk=%b done=%b want 0 0", outclk[2], done[2]); end
    base = cap.size();
    rst = 1'b1;
    step();
    rst = 1'b0; dsr[2] = 1'b1;
    checks++; if (rdy[2] !== 1'b1 || ovf[2] !== 1'b0) begin
      errors++; $display("FAIL rf_after got rdy=%b ovf=%b want 1 0", rdy[2], ovf[2]); end
    checks++; if (outclk[2] !== 1'b0 || done[2] !== 1'b0 || o2 !== 12'h000) begin
      errors++; $display("FAIL rf_outs got outclk=%b done=%b out=%h want 0 0 000", outclk[2], done[2], o2); end
    repeat (6) step();
    checks++; if (cap.size() != base) begin errors++; $display("FAIL rf_no_word got %0d want %0d", cap.size(), base); end
    checks++; if (done_cnt[2] != d2) begin errors++; $display("FAIL rf_no_done got %0d want %0d", done_cnt[2], d2); end
  endtask

  initial begin
    test_reset();
    test_8to2();
    test_2to8();
    test_8to12();
    test_flush_pad();
    test_overflow_stall();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
